// File: rtl/mux_8x1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_8x1_rr
// Purpose  : Eight-lane round-robin multiplexer with valid/ready handshakes
//            and a single registered output stage. Each output word carries
//            the 3-bit index of the lane it came from, which is the select a
//            downstream 1-to-8 demultiplexer uses to route it back out.
//            Throughput is one word per clock.
// Ports    : clk            rising-edge clock
//            rst            synchronous active-high reset
//            a..h  [W]      lane data (index 0..7)
//            va..vh         lane valid
//            ra..rh         lane ready (combinational, at most one high)
//            y     [W]      output data (registered)
//            ys    [3]      source lane index of y (registered)
//            yv             output valid (registered)
//            yr             downstream ready
// Config   : `define MUX_8X1_RR_PRIO_EN makes lane a (index 0) a strict
//            high-priority lane; lanes 1..7 share the remaining cycles
//            round-robin. Undefined: plain eight-way round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mux_8x1_rr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [W-1:0] e,
    input  logic [W-1:0] f,
    input  logic [W-1:0] g,
    input  logic [W-1:0] h,
    input  logic         va,
    input  logic         vb,
    input  logic         vc,
    input  logic         vd,
    input  logic         ve,
    input  logic         vf,
    input  logic         vg,
    input  logic         vh,
    output logic         ra,
    output logic         rb,
    output logic         rc,
    output logic         rd,
    output logic         re,
    output logic         rf,
    output logic         rg,
    output logic         rh,
    output logic [W-1:0] y,
    output logic [2:0]   ys,
    output logic         yv,
    input  logic         yr
);

`ifdef MUX_8X1_RR_PRIO_EN
    localparam bit c_PRIO_EN = 1'b1;
`else
    localparam bit c_PRIO_EN = 1'b0;
`endif

    logic [W-1:0] r_y;
    logic [2:0]   r_ys;
    logic         r_yv;
    logic [2:0]   r_ptr;

    logic [7:0]   w_valid;
    logic [W-1:0] w_data [8];
    logic         w_load;
    logic         w_found;
    logic [2:0]   w_sel;
    logic [2:0]   w_idx;
    logic         w_grant;
    logic [7:0]   w_ready;

    assign w_valid = {vh, vg, vf, ve, vd, vc, vb, va};
    assign w_data[0] = a;
    assign w_data[1] = b;
    assign w_data[2] = c;
    assign w_data[3] = d;
    assign w_data[4] = e;
    assign w_data[5] = f;
    assign w_data[6] = g;
    assign w_data[7] = h;

    // Register is empty, or its word leaves on this edge.
    assign w_load = ~r_yv | yr;

    // Rotating search starting at r_ptr. In priority mode lane 0 wins
    // outright when valid and is otherwise excluded from the rotation.
    always_comb begin
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_idx   = 3'd0;
        if (c_PRIO_EN && w_valid[0]) begin
            w_found = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && w_valid[w_idx] && !(c_PRIO_EN && (w_idx == 3'd0))) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Reset blocks the grant so no lane word is consumed in a reset cycle.
    assign w_grant = w_found & w_load & ~rst;
    assign w_ready = w_grant ? (8'd1 << w_sel) : 8'd0;

    assign ra = w_ready[0];
    assign rb = w_ready[1];
    assign rc = w_ready[2];
    assign rd = w_ready[3];
    assign re = w_ready[4];
    assign rf = w_ready[5];
    assign rg = w_ready[6];
    assign rh = w_ready[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y   <= '0;
            r_ys  <= 3'd0;
            r_yv  <= 1'b0;
            r_ptr <= 3'd0;
        end else if (w_load) begin
            if (w_grant) begin
                r_y  <= w_data[w_sel];
                r_ys <= w_sel;
                r_yv <= 1'b1;
                // A priority grant to lane 0 leaves the rotation untouched.
                if (!(c_PRIO_EN && (w_sel == 3'd0))) begin
                    r_ptr <= w_sel + 3'd1;
                end
            end else begin
                r_yv <= 1'b0;
            end
        end
    end

    assign y  = r_y;
    assign ys = r_ys;
    assign yv = r_yv;

endmodule
`default_nettype wire

// File: tb/tb_mux_8x1_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_8x1_rr
// Purpose  : Directed self-checking bench for mux_8x1_rr. Inputs change 1ns
//            after a rising edge; readies are sampled once inputs settle and
//            registered outputs 1ns after the edge that updates them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_8x1_rr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, c, d, e, f, g, h;
    logic         va, vb, vc, vd, ve, vf, vg, vh;
    logic         ra, rb, rc, rd, re, rf, rg, rh;
    logic [W-1:0] y;
    logic [2:0]   ys;
    logic         yv;
    logic         yr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_8x1_rr #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .va(va), .vb(vb), .vc(vc), .vd(vd), .ve(ve), .vf(vf), .vg(vg), .vh(vh),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd), .re(re), .rf(rf), .rg(rg), .rh(rh),
        .y(y), .ys(ys), .yv(yv), .yr(yr)
    );

    function automatic logic [7:0] rdy();
        return {rh, rg, rf, re, rd, rc, rb, ra};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valids(input logic [7:0] v);
        {vh, vg, vf, ve, vd, vc, vb, va} = v;
    endtask

    initial begin
        rst = 1'b1; yr = 1'b0;
        a = 8'h0; b = 8'h0; c = 8'h0; d = 8'h0;
        e = 8'h0; f = 8'h0; g = 8'h0; h = 8'h0;
        set_valids(8'h00);

        // ---- reset, then idle ----
        step(); step();
        chk("rst_yv", yv, 0);
        chk("rst_y", y, 0);
        chk("rst_ys", ys, 0);
        vc = 1'b1; yr = 1'b1; #1;
        chk("rst_rdy_blocked", rdy(), 8'h00);
        step();
        vc = 1'b0; rst = 1'b0;
        step();
        chk("rst_no_xfer_yv", yv, 0);
        for (int i = 0; i < 10; i++) begin
            chk("idle_out", {yv, ys, y}, 12'h000);
            chk("idle_rdy", rdy(), 8'h00);
            step();
        end

        // ---- single lane ----
        c = 8'h5A; vc = 1'b1; #1;
        chk("single_rc", rdy(), 8'h04);
        step();
        chk("single_y", y, 8'h5A);
        chk("single_ys", ys, 2);
        chk("single_yv", yv, 1);
        vc = 1'b0; #1;
        chk("single_rdy_idle", rdy(), 8'h00);
        step();
        chk("single_drain_yv", yv, 0);
        chk("single_hold_y", y, 8'h5A);
        chk("single_hold_ys", ys, 2);

        // ---- reset while a word is held ----
        c = 8'h33; vc = 1'b1; yr = 1'b0;
        step();
        chk("midrst_loaded", {yv, ys, y}, {1'b1, 3'd2, 8'h33});
        vc = 1'b0; rst = 1'b1;
        step();
        chk("midrst_out", {yv, ys, y}, 12'h000);
        rst = 1'b0; yr = 1'b1;

`ifdef MUX_8X1_RR_PRIO_EN
        // ---- strict priority of lane a ----
        a = 8'hA0; d = 8'hD3;
        set_valids(8'b0000_1001);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("prio_rdy_a", rdy(), 8'h01);
            step();
            chk("prio_ys0", {yv, ys, y}, {1'b1, 3'd0, 8'hA0});
        end
        va = 1'b0; #1;
        chk("prio_rdy_d", rdy(), 8'h08);
        step();
        chk("prio_ys3", {yv, ys, y}, {1'b1, 3'd3, 8'hD3});
        set_valids(8'h00);
        step();
        chk("prio_drain", yv, 0);
`else
        // ---- all lanes busy: strict rotation, no bubbles ----
        a = 8'd0; b = 8'd1; c = 8'd2; d = 8'd3;
        e = 8'd4; f = 8'd5; g = 8'd6; h = 8'd7;
        set_valids(8'hFF);
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("busy_rdy", rdy(), 8'd1 << (i % 8));
            step();
            chk("busy_out", {yv, ys, y}, {1'b1, 3'(i % 8), 8'(i % 8)});
        end

        // ---- back-pressure: lane 7's word held, ptr at 0 ----
        yr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rdy", rdy(), 8'h00);
            step();
            chk("bp_hold", {yv, ys, y}, {1'b1, 3'd7, 8'd7});
        end
        yr = 1'b1; #1;
        chk("bp_release_rdy", rdy(), 8'h01);
        step();
        chk("bp_reload", {yv, ys, y}, {1'b1, 3'd0, 8'd0});
        set_valids(8'h00);
        step();
        chk("bp_drain", yv, 0);

        // ---- wrap and skip: move ptr to 4 via lane d, then only b and h ----
        vd = 1'b1;
        step();
        chk("wrap_pre_d", {yv, ys}, {1'b1, 3'd3});
        vd = 1'b0;
        b = 8'hB1; h = 8'hE7;
        set_valids(8'b1000_0010);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i % 2 == 0) chk("wrap_h", {yv, ys, y}, {1'b1, 3'd7, 8'hE7});
            else            chk("wrap_b", {yv, ys, y}, {1'b1, 3'd1, 8'hB1});
        end
        set_valids(8'h00);
        step();
        chk("wrap_drain", yv, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
